// File: rtl/sd_sector_responder_pkg.sv
// Shared types and constants for the sd_bus sector responder.
package sd_sector_responder_pkg;

  parameter int SD_SECTOR_BYTES = 512;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RD_REQ,
    RD_PUT,
    WR_ADDR,
    WR_LATCH,
    WR_REQ,
    DONE
  } sd_resp_state_t;

endpackage

// File: rtl/sd_sector_responder_check.sv
// Range and permission check for a latched sector request; purely combinational.
module sd_request_check
  import sd_sector_responder_pkg::*;
#(
  parameter int SECTOR_BYTES = SD_SECTOR_BYTES
) (
  input  logic [31:0] lba,
  input  logic [31:0] size,
  input  logic        mounted,
  input  logic        readonly,
  input  logic        dir_wr,
  output logic        reject
);

  localparam int IDX_W = $clog2(SECTOR_BYTES);
  // Wide enough that the end-of-sector byte offset can never wrap.
  localparam int END_W = 32 + IDX_W + 1;

  logic [END_W-1:0] sector_end;

  always_comb begin
    sector_end = ({{(IDX_W + 1){1'b0}}, lba} << IDX_W) + END_W'(SECTOR_BYTES);
    reject     = !mounted || (sector_end > END_W'(size)) || (dir_wr && readonly);
  end

endmodule

// File: rtl/sd_sector_responder.sv
// Responder side of the sd_bus sector protocol: serves sector reads/writes from an SDRAM disk image.
module sd_sector_responder
  import sd_sector_responder_pkg::*;
#(
  parameter int SECTOR_BYTES = SD_SECTOR_BYTES,
  parameter int RAM_AW       = 27
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sd_rd,
  input  logic              sd_wr,
  input  logic [31:0]       sd_lba,
  input  logic [7:0]        sd_wdata,
  output logic              sd_ack,
  output logic [13:0]       sd_buff_addr,
  output logic [7:0]        sd_buff_data,
  output logic              sd_buff_wr,
  input  logic              img_mounted,
  input  logic [31:0]       img_size,
  input  logic              img_readonly,
  input  logic [RAM_AW-1:0] img_base,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              ram_ready,
  output logic              err
);

  localparam int               IDX_W    = $clog2(SECTOR_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECTOR_BYTES - 1);

  sd_resp_state_t   state_q, state_d;
  logic [31:0]      lba_q, lba_d;
  logic [31:0]      size_q, size_d;
  logic             mounted_q, mounted_d;
  logic             readonly_q, readonly_d;
  logic             dir_wr_q, dir_wr_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [7:0]       wdata_q, wdata_d;

  logic              reject;
  logic [RAM_AW-1:0] byte_addr;

  sd_request_check #(.SECTOR_BYTES(SECTOR_BYTES)) u_check (
    .lba      (lba_q),
    .size     (size_q),
    .mounted  (mounted_q),
    .readonly (readonly_q),
    .dir_wr   (dir_wr_q),
    .reject   (reject)
  );

  // Image offset wraps silently at the SDRAM address width.
  assign byte_addr = img_base + RAM_AW'({lba_q, {IDX_W{1'b0}}}) + RAM_AW'(n_q);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
    state_d      = state_q;
    lba_d        = lba_q;
    size_d       = size_q;
    mounted_d    = mounted_q;
    readonly_d   = readonly_q;
    dir_wr_d     = dir_wr_q;
    n_d          = n_q;
    rdata_d      = rdata_q;
    wdata_d      = wdata_q;
    sd_ack       = 1'b0;
    sd_buff_addr = '0;
    sd_buff_data = '0;
    sd_buff_wr   = 1'b0;
    ram_addr     = '0;
    ram_rd       = 1'b0;
    ram_wr       = 1'b0;
    ram_wdata    = '0;
    err          = 1'b0;

    case (state_q)
      IDLE: begin
        if (sd_rd || sd_wr) begin
          lba_d      = sd_lba;
          size_d     = img_size;
          mounted_d  = img_mounted;
          readonly_d = img_readonly;
          dir_wr_d   = !sd_rd;
          n_d        = '0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        sd_ack = 1'b1;
        if (reject) begin
          err     = 1'b1;
          state_d = DONE;
        end else begin
          state_d = dir_wr_q ? WR_ADDR : RD_REQ;
        end
      end
      RD_REQ: begin
        sd_ack   = 1'b1;
        ram_rd   = 1'b1;
        ram_addr = byte_addr;
        if (ram_ready) begin
          rdata_d = ram_rdata;
          state_d = RD_PUT;
        end
      end
      RD_PUT: begin
        sd_ack       = 1'b1;
        sd_buff_wr   = 1'b1;
        sd_buff_addr = 14'(n_q);
        sd_buff_data = rdata_q;
        n_d          = n_q + IDX_W'(1);
        state_d      = (n_q == LAST_IDX) ? DONE : RD_REQ;
      end
      WR_ADDR: begin
        sd_ack       = 1'b1;
        sd_buff_addr = 14'(n_q);
        state_d      = WR_LATCH;
      end
      WR_LATCH: begin
        // Initiator buffer answers one cycle after the address was shown.
        sd_ack       = 1'b1;
        sd_buff_addr = 14'(n_q);
        wdata_d      = sd_wdata;
        state_d      = WR_REQ;
      end
      WR_REQ: begin
        sd_ack       = 1'b1;
        sd_buff_addr = 14'(n_q);
        ram_wr       = 1'b1;
        ram_addr     = byte_addr;
        ram_wdata    = wdata_q;
        if (ram_ready) begin
          n_d     = n_q + IDX_W'(1);
          state_d = (n_q == LAST_IDX) ? DONE : WR_ADDR;
        end
      end
      DONE: begin
        // Wait for the request to drop so a held request is served only once.
        if (!sd_rd && !sd_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lba_q      <= '0;
      size_q     <= '0;
      mounted_q  <= 1'b0;
      readonly_q <= 1'b0;
      dir_wr_q   <= 1'b0;
      n_q        <= '0;
      rdata_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      lba_q      <= lba_d;
      size_q     <= size_d;
      mounted_q  <= mounted_d;
      readonly_q <= readonly_d;
      dir_wr_q   <= dir_wr_d;
      n_q        <= n_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_sd_sector_responder.sv
// Self-checking bench: random-latency SDRAM model, initiator buffer model and transfer-level reference checks.
module tb_sd_sector_responder;

  localparam int SB = 512;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sd_rd = 1'b0, sd_wr = 1'b0;
  logic [31:0] sd_lba = '0;
  logic [7:0]  sd_wdata;
  logic        sd_ack;
  logic [13:0] sd_buff_addr;
  logic [7:0]  sd_buff_data;
  logic        sd_buff_wr;
  logic        img_mounted = 1'b0;
  logic [31:0] img_size = '0;
  logic        img_readonly = 1'b0;
  logic [26:0] img_base = '0;
  logic [26:0] ram_addr;
  logic        ram_rd, ram_wr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_ready;
  logic        err;

  sd_sector_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_lba       (sd_lba),
    .sd_wdata     (sd_wdata),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_data (sd_buff_data),
    .sd_buff_wr   (sd_buff_wr),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .img_readonly (img_readonly),
    .img_base     (img_base),
    .ram_addr     (ram_addr),
    .ram_rd       (ram_rd),
    .ram_wr       (ram_wr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .ram_ready    (ram_ready),
    .err          (err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [26:0] addr;
    logic [7:0]  data;
    logic        wr;
  } ram_txn_t;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  data;
  } strobe_t;

  ram_txn_t   ram_log[$];
  strobe_t    strobe_log[$];
  logic [7:0] wmem [int unsigned];
  logic [7:0] wkey = 8'h00;

  int vectors = 0, miscompares = 0;
  int ack_rises = 0, err_cnt = 0, both_cnt = 0, hi_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [26:0] a);
    return a[7:0] ^ {a[12:8], 3'b101} ^ a[22:15];
  endfunction

  function automatic logic [7:0] mem_byte(input logic [26:0] a);
    if (wmem.exists(32'(a))) return wmem[32'(a)];
    return init_byte(a);
  endfunction

  // SDRAM model: ready pulse after 1..12 cycles, rdata scrambled outside the ready pulse.
  initial begin
    int cnt;
    cnt = 0;
    ram_ready = 1'b0;
    ram_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (ram_ready) begin
        ram_ready = 1'b0;
        ram_rdata = 8'($urandom);
      end else if (ram_rd || ram_wr) begin
        if (cnt == 0) cnt = $urandom_range(1, 12);
        cnt--;
        if (cnt == 0) begin
          ram_ready = 1'b1;
          if (ram_rd) begin
            ram_rdata = mem_byte(ram_addr);
            ram_log.push_back('{ram_addr, ram_rdata, 1'b0});
          end else begin
            wmem[32'(ram_addr)] = ram_wdata;
            ram_log.push_back('{ram_addr, ram_wdata, 1'b1});
          end
        end
      end else begin
        cnt = 0;
        ram_rdata = 8'($urandom);
      end
    end
  end

  // Initiator buffer: byte n is n ^ key, presented one cycle after the address.
  initial begin
    logic [13:0] a;
    sd_wdata = 8'h00;
    forever begin
      @(negedge clk);
      a = sd_buff_addr;
      @(posedge clk);
      #1;
      sd_wdata = a[7:0] ^ wkey;
    end
  end

  initial begin
    logic ack_prev;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (sd_buff_wr) strobe_log.push_back('{sd_buff_addr, sd_buff_data});
      if (sd_ack && !ack_prev) ack_rises++;
      ack_prev = sd_ack;
      if (err) err_cnt++;
      if (ram_rd && ram_wr) both_cnt++;
      if (sd_buff_addr[13:9] != 5'd0) hi_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, " ack"},       64'(sd_ack), 0);
    check({tag, " buff_addr"}, 64'(sd_buff_addr), 0);
    check({tag, " buff_data"}, 64'(sd_buff_data), 0);
    check({tag, " buff_wr"},   64'(sd_buff_wr), 0);
    check({tag, " ram_addr"},  64'(ram_addr), 0);
    check({tag, " ram_rd"},    64'(ram_rd), 0);
    check({tag, " ram_wr"},    64'(ram_wr), 0);
    check({tag, " ram_wdata"}, 64'(ram_wdata), 0);
    check({tag, " err"},       64'(err), 0);
  endtask

  // One complete request; expectations derived from the transfer rules, not the DUT.
  task automatic run_xfer(input string tag, input logic rd, input logic wr,
                          input logic [31:0] lba, input logic mnt, input logic [31:0] size,
                          input logic ro, input logic [26:0] base, input logic [7:0] key,
                          input int hold);
    int s0, r0, e0, a0, t;
    logic is_wr, rej;
    logic [63:0] sector_end, sector_off;
    logic [26:0] exp_addr;
    img_mounted  = mnt;
    img_size     = size;
    img_readonly = ro;
    img_base     = base;
    wkey         = key;
    @(negedge clk);
    s0 = strobe_log.size();
    r0 = ram_log.size();
    e0 = err_cnt;
    a0 = ack_rises;
    sd_lba = lba;
    sd_rd  = rd;
    sd_wr  = wr;
    t = 0;
    while (!sd_ack && t < 8) begin
      @(negedge clk);
      t++;
    end
    check({tag, " ack_rise"}, 64'(sd_ack), 1);
    // Latched fields must be immune to changes after acceptance.
    sd_lba       = $urandom;
    img_size     = $urandom;
    img_mounted  = 1'($urandom);
    img_readonly = 1'($urandom);
    t = 0;
    while (sd_ack && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " ack_drop"}, 64'(sd_ack), 0);
    repeat (hold) @(negedge clk);
    check({tag, " single_serve"}, 64'(ack_rises - a0), 1);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    repeat (3) @(negedge clk);

    is_wr      = wr && !rd;
    sector_off = 64'(lba) * 64'(SB);
    sector_end = sector_off + 64'(SB);
    rej        = !mnt || (sector_end > 64'(size)) || (is_wr && ro);

    check({tag, " err_pulses"}, 64'(err_cnt - e0), rej ? 64'd1 : 64'd0);
    check({tag, " strobes"}, 64'(strobe_log.size() - s0), (rej || is_wr) ? 64'd0 : 64'(SB));
    check({tag, " ram_accesses"}, 64'(ram_log.size() - r0), rej ? 64'd0 : 64'(SB));
    if (!rej) begin
      for (int i = 0; i < SB; i++) begin
        exp_addr = 27'(64'(base) + sector_off + 64'(i));
        if (r0 + i < ram_log.size()) begin
          check({tag, $sformatf(" ram_addr[%0d]", i)}, 64'(ram_log[r0 + i].addr), 64'(exp_addr));
          check({tag, $sformatf(" ram_dir[%0d]", i)}, 64'(ram_log[r0 + i].wr), 64'(is_wr));
          if (is_wr)
            check({tag, $sformatf(" ram_wdata[%0d]", i)}, 64'(ram_log[r0 + i].data),
                  64'(8'(i) ^ key));
        end
        if (!is_wr && (s0 + i < strobe_log.size())) begin
          check({tag, $sformatf(" buff_addr[%0d]", i)}, 64'(strobe_log[s0 + i].addr), 64'(i));
          check({tag, $sformatf(" buff_data[%0d]", i)}, 64'(strobe_log[s0 + i].data),
                64'(mem_byte(exp_addr)));
        end
      end
    end
  endtask

  initial begin
    int s0, a0, t;
    logic rd, wr;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer("rd_lba3",      1'b1, 1'b0, 32'd3,          1'b1, 32'd4096, 1'b0, 27'h100000, 8'h00, 2);
    run_xfer("wr_lba0",      1'b0, 1'b1, 32'd0,          1'b1, 32'd4096, 1'b0, 27'h100000, 8'h5A, 2);
    run_xfer("rd_lba8_oor",  1'b1, 1'b0, 32'd8,          1'b1, 32'd4096, 1'b0, 27'h100000, 8'h00, 2);
    run_xfer("rd_lba_ovf",   1'b1, 1'b0, 32'h0080_0000,  1'b1, 32'd4096, 1'b0, 27'h100000, 8'h00, 2);
    run_xfer("wr_readonly",  1'b0, 1'b1, 32'd1,          1'b1, 32'd4096, 1'b1, 27'h100000, 8'h33, 2);
    run_xfer("rd_unmounted", 1'b1, 1'b0, 32'd0,          1'b0, 32'd4096, 1'b0, 27'h100000, 8'h00, 2);
    run_xfer("rd_last_ok",   1'b1, 1'b0, 32'd7,          1'b1, 32'd4096, 1'b1, 27'h100000, 8'h00, 2);
    run_xfer("rd_wr_both",   1'b1, 1'b1, 32'd0,          1'b1, 32'd4096, 1'b0, 27'h100000, 8'hC3, 20);
    run_xfer("rd_rerun",     1'b1, 1'b0, 32'd0,          1'b1, 32'd4096, 1'b0, 27'h100000, 8'h00, 2);
    run_xfer("rd_addr_wrap", 1'b1, 1'b0, 32'd0,          1'b1, 32'd4096, 1'b0, 27'h7FFFF00, 8'h00, 2);

    // Reset in the middle of a read transfer.
    img_mounted  = 1'b1;
    img_size     = 32'd4096;
    img_readonly = 1'b0;
    img_base     = 27'h100000;
    @(negedge clk);
    s0 = strobe_log.size();
    sd_lba = 32'd1;
    sd_rd  = 1'b1;
    t = 0;
    while ((strobe_log.size() - s0) < 100 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("rst reached_byte100", 64'(strobe_log.size() - s0), 100);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    sd_rd = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    s0 = strobe_log.size();
    a0 = ack_rises;
    repeat (40) @(negedge clk);
    check("rst no_more_strobes", 64'(strobe_log.size() - s0), 0);
    check("rst no_more_ack", 64'(ack_rises - a0), 0);

    for (int k = 0; k < 3; k++) begin
      rd = 1'($urandom);
      wr = !rd || 1'($urandom);
      run_xfer($sformatf("rand%0d", k), rd, wr, 32'($urandom_range(0, 9)), 1'b1, 32'd4096,
               ($urandom_range(0, 3) == 0), 27'($urandom), 8'($urandom), 2);
    end

    check("never_rd_and_wr", 64'(both_cnt), 0);
    check("buff_addr_high_zero", 64'(hi_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
